// File: rtl/decoder_rx.sv
// decoder_rx: receive side of the reduced-line link. It takes 3-bit codes with an even
// parity bit over a valid/ready handshake and drops words whose parity is wrong. Good
// codes go into a small first-word-fall-through FIFO. The head entry is shown as an
// 8-bit one-hot value.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   in_a2value..in_a0value    encoded word {a2,a1,a0}
//   in_par                    even parity over the three code bits
//   EN_dec / RDY_dec          source offer / decoder can accept (FIFO not full)
//   dec_y / RDY_out           one-hot head entry (0 when empty) / head valid
//   EN_take                   consumer pops the head entry
//   err_flag                  one-cycle pulse after a parity drop
//   err_cnt                   saturating count of dropped words
//   occupancy                 entries currently held
module decoder_rx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_a2value,
  input  logic                   in_a1value,
  input  logic                   in_a0value,
  input  logic                   in_par,
  input  logic                   EN_dec,
  output logic                   RDY_dec,
  output logic [7:0]             dec_y,
  output logic                   RDY_out,
  input  logic                   EN_take,
  output logic                   err_flag,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_t;

  fifo_state_t      state_q;
  fifo_state_t      state_d;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [OCC_W-1:0] occ_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic             err_flag_d;

  logic [2:0]       mem [DEPTH];

  logic [2:0]       code;
  logic             par_ok;
  logic             handshake;
  logic             push;
  logic             pop;

  // Handshake qualification. The ready signals depend only on the registered state.
  assign code      = {in_a2value, in_a1value, in_a0value};
  assign par_ok    = (in_par == ^code);
  assign RDY_dec   = (state_q != ST_FULL);
  assign RDY_out   = (state_q != ST_EMPTY);
  assign handshake = EN_dec && RDY_dec;
  assign push      = handshake && par_ok;
  assign pop       = EN_take && RDY_out;

  // State register and bookkeeping registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_EMPTY;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      occupancy <= occ_d;
      err_cnt   <= err_cnt_d;
      err_flag  <= err_flag_d;
    end
  end

  // Next-state logic. The FIFO state tracks occupancy: EMPTY, PART or FULL.
  always_comb begin
    state_d    = state_q;
    occ_d      = occupancy;
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr;
    err_flag_d = 1'b0;
    err_cnt_d  = err_cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr + PTR_W'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        // pop is impossible here because RDY_out is low.
        if (push) begin
          occ_d   = OCC_W'(1);
          state_d = ST_PART;
        end
      end
      ST_PART: begin
        if (push && !pop) begin
          occ_d = occupancy + OCC_W'(1);
          if (occupancy == OCC_W'(DEPTH - 1)) begin
            state_d = ST_FULL;
          end
        end else if (pop && !push) begin
          occ_d = occupancy - OCC_W'(1);
          if (occupancy == OCC_W'(1)) begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_FULL: begin
        // push is impossible here because RDY_dec is low.
        if (pop) begin
          occ_d   = occupancy - OCC_W'(1);
          state_d = ST_PART;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        occ_d   = '0;
      end
    endcase

    // A parity drop still completes the handshake. It is counted but not stored.
    if (handshake && !par_ok) begin
      err_flag_d = 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt + CNT_W'(1);
      end
    end
  end

  // Storage needs no reset. Reset blocks a push in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem[wr_ptr] <= code;
    end
  end

  // One-hot decode of the head entry, held at zero while empty.
  always_comb begin
    dec_y = 8'h00;
    if (RDY_out) begin
      dec_y[mem[rd_ptr]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_rx.sv
// Testbench for decoder_rx. A queue-based reference model predicts every output
// after each clock edge. Directed scenarios run first, then randomized traffic.
module tb_decoder_rx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             in_a2value = 1'b0;
  logic             in_a1value = 1'b0;
  logic             in_a0value = 1'b0;
  logic             in_par = 1'b0;
  logic             EN_dec = 1'b0;
  logic             EN_take = 1'b0;
  logic             RDY_dec;
  logic [7:0]       dec_y;
  logic             RDY_out;
  logic             err_flag;
  logic [CNT_W-1:0] err_cnt;
  logic [2:0]       occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit [2:0] q[$];
  bit       m_flag;
  int       m_cnt;

  decoder_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .in_a2value(in_a2value), .in_a1value(in_a1value), .in_a0value(in_a0value),
    .in_par(in_par), .EN_dec(EN_dec), .RDY_dec(RDY_dec),
    .dec_y(dec_y), .RDY_out(RDY_out), .EN_take(EN_take),
    .err_flag(err_flag), .err_cnt(err_cnt), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  // Expected output vector {RDY_dec, RDY_out, dec_y, occupancy, err_flag, err_cnt}.
  function automatic logic [21:0] exp_vec();
    logic [7:0] y;
    y = 8'h00;
    if (q.size() != 0) y[q[0]] = 1'b1;
    return {q.size() != DEPTH, q.size() != 0, y, 3'(q.size()), m_flag, 8'(m_cnt)};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {RDY_dec, RDY_out, dec_y, occupancy, err_flag, err_cnt};
  endfunction

  // Drive one cycle of inputs, clock it, then advance the model.
  task automatic step(input bit rst, input bit en, input bit [2:0] c, input bit p, input bit tk);
    bit hs, ok, pp;
    RST = rst; EN_dec = en; {in_a2value, in_a1value, in_a0value} = c; in_par = p; EN_take = tk;
    @(posedge CLK); #1;
    if (rst) begin
      q.delete(); m_flag = 0; m_cnt = 0;
    end else begin
      hs = en && (q.size() < DEPTH);
      ok = (p == ^c);
      pp = tk && (q.size() > 0);
      if (pp) void'(q.pop_front());
      if (hs && ok) q.push_back(c);
      m_flag = hs && !ok;
      if (hs && !ok && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic idle();
    step(0, 0, 3'd0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 3'd0, 0, 0);
    checks++;
    if (dut_vec() !== 22'b1_0_00000000_000_0_00000000) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec(), 22'b1_0_00000000_000_0_00000000);
    end
  endtask

  task automatic test_single();
    step(1, 0, 3'd0, 0, 0);
    step(0, 1, 3'd5, 0, 0);
    checks++;
    if ({RDY_out, dec_y, occupancy, err_flag} !== {1'b1, 8'h20, 3'd1, 1'b0}) begin
      errors++; $display("FAIL single_push got %b/%h/%0d/%b exp 1/20/1/0", RDY_out, dec_y, occupancy, err_flag);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] want;
    step(1, 0, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'(i), ^(3'(i)), 0);
    checks++;
    if ({occupancy, RDY_dec} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL fill_full got occ=%0d rdy_dec=%b exp occ=4 rdy_dec=0", occupancy, RDY_dec);
    end
    step(0, 1, 3'd7, 1, 0);
    checks++;
    if (occupancy !== 3'd4 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL push_when_full got %h exp %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      want = 8'h01 << i;
      checks++;
      if (dec_y !== want) begin
        errors++; $display("FAIL drain_order_%0d got %h exp %h", i, dec_y, want);
      end
      step(0, 0, 3'd0, 0, 1);
    end
    checks++;
    if ({RDY_out, dec_y} !== 9'h000) begin
      errors++; $display("FAIL drain_empty got rdy_out=%b dec_y=%h exp 0/00", RDY_out, dec_y);
    end
  endtask

  task automatic test_parity_err();
    step(1, 0, 3'd0, 0, 0);
    step(0, 1, 3'd6, 1, 0);
    checks++;
    if ({occupancy, err_flag, err_cnt} !== {3'd0, 1'b1, 8'd1}) begin
      errors++; $display("FAIL parity_drop got occ=%0d flag=%b cnt=%0d exp 0/1/1", occupancy, err_flag, err_cnt);
    end
    idle();
    checks++;
    if ({err_flag, err_cnt} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL parity_pulse got flag=%b cnt=%0d exp 0/1", err_flag, err_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 3'd6, 1, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL parity_repeat_%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    idle();
    checks++;
    if ({err_flag, err_cnt, occupancy} !== {1'b0, 8'd255, 3'd0}) begin
      errors++; $display("FAIL err_saturate got flag=%b cnt=%0d occ=%0d exp 0/255/0", err_flag, err_cnt, occupancy);
    end
  endtask

  task automatic test_full_push_pop();
    step(1, 0, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'(i + 2), ^(3'(i + 2)), 0);
    step(0, 1, 3'd1, 1, 1);
    checks++;
    if ({occupancy, RDY_dec, dec_y} !== {3'd3, 1'b1, 8'h08}) begin
      errors++; $display("FAIL full_pushpop got occ=%0d rdy_dec=%b y=%h exp 3/1/08", occupancy, RDY_dec, dec_y);
    end
    step(0, 1, 3'd1, 1, 0);
    checks++;
    if ({occupancy, RDY_dec} !== {3'd4, 1'b0} || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL full_refill got %h exp %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL full_drain_%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
      step(0, 0, 3'd0, 0, 1);
    end
  endtask

  task automatic test_back_to_back();
    bit [2:0] c;
    step(1, 0, 3'd0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      c = 3'(7 - (i % 8));
      checks++;
      if (i > 0 && dec_y !== (8'h01 << (3'(8 - (i % 8)) ))) begin
        errors++; $display("FAIL stream_order_%0d got %h exp %h", i, dec_y, 8'h01 << 3'(8 - (i % 8)));
      end
      step(0, 1, c, ^c, 1);
      checks++;
      if (occupancy !== 3'd1 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stream_%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(1, 0, 3'd0, 0, 0);
    step(0, 1, 3'd2, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd1, 1, 0);
    step(0, 1, 3'd4, 0, 0);
    step(1, 1, 3'd3, 0, 0);
    checks++;
    if ({occupancy, RDY_out, dec_y, err_cnt, RDY_dec} !== {3'd0, 1'b0, 8'h00, 8'd0, 1'b1}) begin
      errors++; $display("FAIL reset_mid got occ=%0d rdy_out=%b y=%h cnt=%0d", occupancy, RDY_out, dec_y, err_cnt);
    end
    idle();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_mid_idle got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit [2:0] c;
    bit p, en, tk, rst;
    step(1, 0, 3'd0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      c   = 3'($urandom_range(0, 7));
      p   = ($urandom_range(0, 99) < 85) ? ^c : ~^c;
      en  = $urandom_range(0, 99) < 65;
      tk  = $urandom_range(0, 99) < 50;
      rst = $urandom_range(0, 199) == 0;
      step(rst, en, c, p, tk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    m_flag = 0;
    m_cnt  = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_parity_err();
    test_full_push_pop();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
